// File: rtl/iq_sdram_writer.sv
// iq_sdram_writer: packs 24-bit IQ pairs from the RX sample FIFO into 32-bit
// words, buffers them, and writes them as pipelined Wishbone bursts into a
// circular SDRAM region.
module iq_sdram_writer #(
    parameter int unsigned            IQ_PAIR_WIDTH = 24,
    parameter int unsigned            DATA_WIDTH    = 32,
    parameter int unsigned            ADDR_WIDTH    = 24,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR     = ADDR_WIDTH'(24'h000000),
    parameter logic [ADDR_WIDTH-1:0]  RING_WORDS    = ADDR_WIDTH'(24'h100000),
    parameter int unsigned            BURST_LEN     = 4,
    parameter int unsigned            BUF_DEPTH     = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     fifo_empty,
    input  logic [IQ_PAIR_WIDTH-1:0] fifo_data,
    output logic                     fifo_rd,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [ADDR_WIDTH-1:0]    addr_o,
    output logic [DATA_WIDTH-1:0]    data_o,
    input  logic                     stall_i,
    input  logic                     ack_i,
    output logic [ADDR_WIDTH-1:0]    wr_ptr,
    output logic [15:0]              wrap_cnt,
    output logic                     busy
);

    localparam int unsigned IDX_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    localparam logic [CNT_W-1:0]      BURST_N   = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]      RD_LIMIT  = CNT_W'(BUF_DEPTH - 2);
    localparam logic [CNT_W-1:0]      FULL_N    = CNT_W'(BUF_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = BASE_ADDR + RING_WORDS - ADDR_WIDTH'(1);

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    // Packer state
    logic                  rd_pending;
    logic                  flush_pending;
    logic [1:0]            phase;
    logic [23:0]           residue;
    logic [1:0]            phase_nxt;
    logic [23:0]           residue_nxt;
    logic                  push_c;
    logic [DATA_WIDTH-1:0] push_data_c;
    logic                  flush_set_c;

    // Word buffer
    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [CNT_W-1:0]      buf_cnt;
    logic                  pop_c;

    // Wishbone master
    state_t                state;
    logic [CNT_W-1:0]      burst_n;
    logic [CNT_W-1:0]      acc_cnt;
    logic [CNT_W-1:0]      ack_cnt;
    logic                  start_c;
    logic [CNT_W-1:0]      start_len_c;
    logic                  accept_c;
    logic                  ack_c;
    logic                  wrap_c;
    logic [ADDR_WIDTH-1:0] ptr_nxt_c;
    logic [IDX_W-1:0]      rd_idx_nxt_c;

    // Read strobe: stop two entries short of full so in-flight samples still fit
    assign fifo_rd = reset_n & enable & ~fifo_empty & (buf_cnt <= RD_LIMIT) & ~flush_pending;

    // Partial-word flush is only scheduled when the buffer has a free slot
    assign flush_set_c = ~enable & ~rd_pending & (phase != 2'd0) & ~flush_pending
                       & (buf_cnt != FULL_N);

    // Little-endian 4-samples-into-3-words packer plus residue flush
    always_comb begin
        push_c      = 1'b0;
        push_data_c = '0;
        phase_nxt   = phase;
        residue_nxt = residue;
        if (rd_pending) begin
            case (phase)
                2'd0: begin
                    residue_nxt = 24'(fifo_data);
                    phase_nxt   = 2'd1;
                end
                2'd1: begin
                    push_c      = 1'b1;
                    push_data_c = {fifo_data[7:0], residue};
                    residue_nxt = {8'h00, fifo_data[23:8]};
                    phase_nxt   = 2'd2;
                end
                2'd2: begin
                    push_c      = 1'b1;
                    push_data_c = {fifo_data[15:0], residue[15:0]};
                    residue_nxt = {16'h0000, fifo_data[23:16]};
                    phase_nxt   = 2'd3;
                end
                default: begin
                    push_c      = 1'b1;
                    push_data_c = {fifo_data[23:0], residue[7:0]};
                    residue_nxt = '0;
                    phase_nxt   = 2'd0;
                end
            endcase
        end else if (flush_pending) begin
            push_c      = 1'b1;
            push_data_c = {8'h00, residue};
            residue_nxt = '0;
            phase_nxt   = 2'd0;
        end
    end

    // Packer registers: pending-read flag, phase, residue, flush request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pending    <= 1'b0;
            flush_pending <= 1'b0;
            phase         <= 2'd0;
            residue       <= '0;
        end else begin
            rd_pending    <= fifo_rd;
            flush_pending <= flush_set_c;
            phase         <= phase_nxt;
            residue       <= residue_nxt;
        end
    end

    // Buffer storage; written only into free slots, so no reset needed
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_idx] <= push_data_c;
        end
    end

    // Buffer pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_idx  <= '0;
            rd_idx  <= '0;
            buf_cnt <= '0;
        end else begin
            if (push_c) begin
                wr_idx <= wr_idx + IDX_W'(1);
            end
            if (pop_c) begin
                rd_idx <= rd_idx_nxt_c;
            end
            case ({push_c, pop_c})
                2'b10:   buf_cnt <= buf_cnt + CNT_W'(1);
                2'b01:   buf_cnt <= buf_cnt - CNT_W'(1);
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

    assign start_c = (buf_cnt >= BURST_N)
                   | (~enable & (phase == 2'd0) & ~rd_pending & (buf_cnt != '0));
    assign start_len_c  = (buf_cnt >= BURST_N) ? BURST_N : buf_cnt;
    assign accept_c     = (state == S_BURST) & stb_o & ~stall_i;
    assign ack_c        = (state == S_BURST) & cyc_o & ack_i & (ack_cnt < burst_n);
    assign pop_c        = accept_c;
    assign wrap_c       = (wr_ptr == LAST_ADDR);
    assign ptr_nxt_c    = wrap_c ? BASE_ADDR : wr_ptr + ADDR_WIDTH'(1);
    assign rd_idx_nxt_c = rd_idx + IDX_W'(1);

    // Wishbone burst FSM with ring pointer and wrap counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cyc_o    <= 1'b0;
            stb_o    <= 1'b0;
            we_o     <= 1'b0;
            addr_o   <= '0;
            data_o   <= '0;
            wr_ptr   <= BASE_ADDR;
            wrap_cnt <= '0;
            burst_n  <= '0;
            acc_cnt  <= '0;
            ack_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_c) begin
                        state   <= S_BURST;
                        cyc_o   <= 1'b1;
                        stb_o   <= 1'b1;
                        we_o    <= 1'b1;
                        addr_o  <= wr_ptr;
                        data_o  <= mem[rd_idx];
                        burst_n <= start_len_c;
                        acc_cnt <= '0;
                        ack_cnt <= '0;
                    end
                end
                S_BURST: begin
                    if (accept_c) begin
                        acc_cnt <= acc_cnt + CNT_W'(1);
                        wr_ptr  <= ptr_nxt_c;
                        if (wrap_c && (wrap_cnt != 16'hFFFF)) begin
                            wrap_cnt <= wrap_cnt + 16'd1;
                        end
                        if ((acc_cnt + CNT_W'(1)) == burst_n) begin
                            stb_o <= 1'b0;
                        end else begin
                            addr_o <= ptr_nxt_c;
                            data_o <= mem[rd_idx_nxt_c];
                        end
                    end
                    if (ack_c) begin
                        ack_cnt <= ack_cnt + CNT_W'(1);
                        if ((ack_cnt + CNT_W'(1)) == burst_n) begin
                            state <= S_IDLE;
                            cyc_o <= 1'b0;
                            stb_o <= 1'b0;
                            we_o  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign busy = rd_pending | (phase != 2'd0) | (buf_cnt != '0) | cyc_o;

endmodule

// File: tb/tb_iq_sdram_writer.sv
// Scoreboard bench for iq_sdram_writer: FIFO model, Wishbone slave model,
// expected-write and expected-burst-length queues checked by a monitor.
module tb_iq_sdram_writer;

    typedef struct packed {
        logic [23:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        fifo_empty = 1'b1;
    logic [23:0] fifo_data  = '0;
    logic        fifo_rd;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [23:0] addr_o;
    logic [31:0] data_o;
    logic        stall_i = 1'b0;
    logic        ack_i   = 1'b0;
    logic [23:0] wr_ptr;
    logic [15:0] wrap_cnt;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [23:0] fifo_q[$];
    wr_t         wq[$];
    int          lq[$];
    int          rd_count  = 0;
    int          stall_seen = 0;

    logic        stall_force = 1'b0;
    int          stall_at    = 99;
    int          stall_cycles = 0;

    iq_sdram_writer #(
        .IQ_PAIR_WIDTH (24),
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (24),
        .BASE_ADDR     (24'h000010),
        .RING_WORDS    (24'h000006),
        .BURST_LEN     (4),
        .BUF_DEPTH     (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .cyc_o      (cyc_o),
        .stb_o      (stb_o),
        .we_o       (we_o),
        .addr_o     (addr_o),
        .data_o     (data_o),
        .stall_i    (stall_i),
        .ack_i      (ack_i),
        .wr_ptr     (wr_ptr),
        .wrap_cnt   (wrap_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Non-FWFT sample FIFO: data appears the cycle after an accepted read
    always begin : fifo_model
        logic r;
        @(posedge clk);
        r = fifo_rd;
        #1;
        if (r) begin
            if (fifo_q.size() > 0) begin
                fifo_data = fifo_q.pop_front();
                rd_count++;
            end else begin
                chk("fifo_rd_on_empty", 32'(r), 32'd0);
            end
        end
        fifo_empty = (fifo_q.size() == 0);
    end

    // Wishbone slave: ack one cycle after each accept, optional stall window
    always begin : slave
        logic acc;
        int   acc_idx;
        int   stall_cnt;
        @(posedge clk);
        acc = cyc_o & stb_o & ~stall_i;
        #1;
        if (!cyc_o) begin
            acc_idx   = 0;
            stall_cnt = 0;
        end else if (acc) begin
            acc_idx++;
        end
        ack_i = acc;
        if (stall_force) begin
            stall_i = 1'b1;
        end else if (cyc_o && stb_o && acc_idx == stall_at && stall_cnt < stall_cycles) begin
            stall_i = 1'b1;
            stall_cnt++;
        end else begin
            stall_i = 1'b0;
        end
    end

    // Monitor: compare accepted writes, stall stability, burst ack counts
    always @(negedge clk) begin : monitor
        logic        prev_cyc;
        logic        prev_hold;
        logic [23:0] prev_addr;
        logic [31:0] prev_data;
        int          burst_acc;
        int          burst_ack;
        wr_t         e;
        int          n;
        if (!reset_n) begin
            prev_cyc  = 1'b0;
            prev_hold = 1'b0;
            burst_acc = 0;
            burst_ack = 0;
        end else begin
            chk("no_overflow", 32'(dut.buf_cnt <= 4'd8), 32'd1);
            if (prev_hold) begin
                chk("stall_addr_hold", 32'(addr_o), 32'(prev_addr));
                chk("stall_data_hold", data_o, prev_data);
            end
            if (cyc_o && stb_o && stall_i) stall_seen++;
            if (cyc_o && stb_o && !stall_i) begin
                burst_acc++;
                chk("we_during_cyc", 32'(we_o), 32'd1);
                if (wq.size() == 0) begin
                    chk("unexpected_write_addr", 32'(addr_o), 32'hFFFFFFFF);
                end else begin
                    e = wq.pop_front();
                    chk("write_addr", 32'(addr_o), 32'(e.addr));
                    chk("write_data", data_o, e.data);
                end
            end
            if (cyc_o && ack_i) burst_ack++;
            if (prev_cyc && !cyc_o) begin
                if (lq.size() == 0) begin
                    chk("unexpected_burst_len", 32'(burst_acc), 32'd0);
                end else begin
                    n = lq.pop_front();
                    chk("burst_accepts", 32'(burst_acc), 32'(n));
                    chk("burst_acks", 32'(burst_ack), 32'(n));
                end
                burst_acc = 0;
                burst_ack = 0;
            end
            prev_cyc  = cyc_o;
            prev_hold = cyc_o & stb_o & stall_i;
            prev_addr = addr_o;
            prev_data = data_o;
        end
    end

    task automatic exp_wr(input logic [23:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        wq.push_back(e);
    endtask

    task automatic wait_fifo(input string name);
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fifo_q.size() == 0 && fifo_empty) break;
        end
        chk({"fifo_drain_", name}, 32'(i < 200), 32'd1);
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int i;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (fifo_q.size() == 0 && wq.size() == 0 && lq.size() == 0 && !cyc_o) break;
        end
        chk({"bus_drain_", name}, 32'(i < 300), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        reset_n = 1'b0;
        wq.delete();
        lq.delete();
        #1;
        chk({name, "_cyc"}, 32'(cyc_o), 32'd0);
        chk({name, "_wr_ptr"}, 32'(wr_ptr), 32'h10);
        chk({name, "_wrap"}, 32'(wrap_cnt), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin : stimulus
        int rd_base;
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cyc",     32'(cyc_o),    32'd0);
        chk("rst_stb",     32'(stb_o),    32'd0);
        chk("rst_we",      32'(we_o),     32'd0);
        chk("rst_addr",    32'(addr_o),   32'd0);
        chk("rst_data",    data_o,        32'd0);
        chk("rst_fifo_rd", 32'(fifo_rd),  32'd0);
        chk("rst_wr_ptr",  32'(wr_ptr),   32'h10);
        chk("rst_wrap",    32'(wrap_cnt), 32'd0);
        chk("rst_busy",    32'(busy),     32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Pack: 4 samples -> 3 words, written as a partial burst once idle
        fifo_q.push_back(24'hABCDEF);
        fifo_q.push_back(24'h123456);
        fifo_q.push_back(24'h789ABC);
        fifo_q.push_back(24'hDEF012);
        exp_wr(24'h10, 32'h56ABCDEF);
        exp_wr(24'h11, 32'h9ABC1234);
        exp_wr(24'h12, 32'hDEF01278);
        lq.push_back(3);
        enable = 1'b1;
        wait_fifo("pack");
        chk("pack_no_early_burst", 32'(cyc_o), 32'd0);
        chk("pack_busy_buffered",  32'(busy),  32'd1);
        enable = 1'b0;
        wait_drain("pack");
        chk("pack_wr_ptr", 32'(wr_ptr), 32'h13);
        chk("pack_busy",   32'(busy),   32'd0);

        // Burst: 8 samples -> 6 words, one 4-word burst, 2 left buffered
        do_reset("rst2");
        fifo_q.push_back(24'h111111);
        fifo_q.push_back(24'h222222);
        fifo_q.push_back(24'h333333);
        fifo_q.push_back(24'h444444);
        fifo_q.push_back(24'h555555);
        fifo_q.push_back(24'h666666);
        fifo_q.push_back(24'h777777);
        fifo_q.push_back(24'h888888);
        exp_wr(24'h10, 32'h22111111);
        exp_wr(24'h11, 32'h33332222);
        exp_wr(24'h12, 32'h44444433);
        exp_wr(24'h13, 32'h66555555);
        lq.push_back(4);
        enable = 1'b1;
        wait_drain("burst");
        repeat (4) @(negedge clk);
        chk("burst_wr_ptr", 32'(wr_ptr), 32'h14);
        chk("burst_busy",   32'(busy),   32'd1);
        chk("burst_idle",   32'(cyc_o),  32'd0);

        // Wrap: remaining 2 words hit the ring end at 0x15 and wrap to 0x10
        exp_wr(24'h14, 32'h77776666);
        exp_wr(24'h15, 32'h88888877);
        lq.push_back(2);
        enable = 1'b0;
        wait_drain("wrap");
        chk("wrap_wr_ptr", 32'(wr_ptr),   32'h10);
        chk("wrap_cnt",    32'(wrap_cnt), 32'd1);
        chk("wrap_busy",   32'(busy),     32'd0);

        // Stall + flush: 5 samples, 3 stall cycles on the 2nd word
        stall_at     = 1;
        stall_cycles = 3;
        stall_seen   = 0;
        fifo_q.push_back(24'hA1B2C3);
        fifo_q.push_back(24'hD4E5F6);
        fifo_q.push_back(24'h0F1E2D);
        fifo_q.push_back(24'h3C4B5A);
        fifo_q.push_back(24'h123456);
        exp_wr(24'h10, 32'hF6A1B2C3);
        exp_wr(24'h11, 32'h1E2DD4E5);
        exp_wr(24'h12, 32'h3C4B5A0F);
        exp_wr(24'h13, 32'h00123456);
        lq.push_back(4);
        enable = 1'b1;
        wait_fifo("flush");
        enable = 1'b0;
        wait_drain("flush");
        stall_cycles = 0;
        chk("stall_cycles_seen", 32'(stall_seen), 32'd3);
        chk("flush_wr_ptr",      32'(wr_ptr),     32'h14);
        chk("flush_wrap",        32'(wrap_cnt),   32'd1);
        chk("flush_busy",        32'(busy),       32'd0);

        // Backpressure: bus stalled, FIFO full of samples
        do_reset("rst4");
        stall_force = 1'b1;
        for (int i = 0; i < 20; i++) fifo_q.push_back(24'(i + 1));
        repeat (2) @(negedge clk);
        rd_base = rd_count;
        enable = 1'b1;
        repeat (40) @(negedge clk);
        chk("bp_reads",   32'(rd_count - rd_base), 32'd11);
        chk("bp_fifo_rd", 32'(fifo_rd), 32'd0);
        chk("bp_cyc",     32'(cyc_o),   32'd1);
        chk("bp_stb",     32'(stb_o),   32'd1);
        chk("bp_busy",    32'(busy),    32'd1);

        // Reset mid-burst drops the bus at once
        @(negedge clk);
        reset_n = 1'b0;
        wq.delete();
        lq.delete();
        #1;
        chk("mid_rst_cyc",     32'(cyc_o),    32'd0);
        chk("mid_rst_stb",     32'(stb_o),    32'd0);
        chk("mid_rst_wr_ptr",  32'(wr_ptr),   32'h10);
        chk("mid_rst_busy",    32'(busy),     32'd0);
        chk("mid_rst_fifo_rd", 32'(fifo_rd),  32'd0);
        enable      = 1'b0;
        stall_force = 1'b0;
        fifo_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_idle", 32'(cyc_o), 32'd0);
        chk("wq_empty", 32'(wq.size()), 32'd0);
        chk("lq_empty", 32'(lq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
